// File: rtl/bp_frame_scheduler_if.sv
// Stream and decoder-handshake bundle for bp_frame_scheduler.
// The slave modport is the scheduler side; master is its environment.
interface bp_frame_scheduler_if #(
    parameter int BIT = 8
);
    logic             s_valid;
    logic             s_ready;
    logic [8*BIT-1:0] s_llr;
    logic             dec_start;
    logic [8*BIT-1:0] dec_llr;
    logic             dec_busy;
    logic [3:0]       dec_bits;
    logic             m_valid;
    logic             m_ready;
    logic [3:0]       m_bits;
    logic [3:0]       m_tag;
    logic             m_err;

    modport slave (
        input  s_valid, s_llr, dec_busy, dec_bits, m_ready,
        output s_ready, dec_start, dec_llr, m_valid, m_bits, m_tag, m_err
    );

    modport master (
        output s_valid, s_llr, dec_busy, dec_bits, m_ready,
        input  s_ready, dec_start, dec_llr, m_valid, m_bits, m_tag, m_err
    );
endinterface

// File: rtl/bp_frame_scheduler.sv
// Frame sequencer for the N=8/K=4 BP decoder: 2-deep tagged input FIFO,
// launch/ack/run watchdogs and a registered tagged result stream.
module bp_frame_scheduler #(
    parameter int BIT         = 8,
    parameter int ACK_TIMEOUT = 4,
    parameter int RUN_TIMEOUT = 2047
) (
    input  logic                clk,
    input  logic                rst_n,
    bp_frame_scheduler_if.slave bus,
    input  logic                clr_err,
    output logic [15:0]         frames_done,
    output logic                err_flag
);
    typedef struct packed {
        logic [3:0]       tag;
        logic [8*BIT-1:0] llr;
    } entry_t;

    typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_ACK, RUN, CAPTURE} state_t;

    entry_t      fifo_mem [2];
    entry_t      head;
    logic        wr_ptr, rd_ptr;
    logic [1:0]  fifo_cnt;
    logic [3:0]  in_tag;
    logic        push, pop, fifo_empty;

    state_t      state_q, state_d;
    logic [11:0] cnt_q, cnt_d;
    logic [3:0]  cur_tag_q, cur_tag_d;
    logic        cur_err_q, cur_err_d;
    logic        load, err_set;

    logic        m_valid_q, m_err_q;
    logic [3:0]  m_bits_q, m_tag_q;

    assign fifo_empty    = (fifo_cnt == 2'd0);
    assign head          = fifo_mem[rd_ptr];
    assign push          = bus.s_valid && bus.s_ready;
    assign bus.s_ready   = (fifo_cnt != 2'd2);
    assign bus.dec_llr   = fifo_empty ? '0 : head.llr;
    assign bus.dec_start = (state_q == LAUNCH);
    assign bus.m_valid   = m_valid_q;
    assign bus.m_bits    = m_bits_q;
    assign bus.m_tag     = m_tag_q;
    assign bus.m_err     = m_err_q;

    // Payload storage needs no reset: dec_llr is gated by the count.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= '{tag: in_tag, llr: bus.s_llr};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            fifo_cnt <= 2'd0;
            in_tag   <= 4'd0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
                in_tag <= in_tag + 4'd1;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= 12'd0;
            cur_tag_q <= 4'd0;
            cur_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cur_tag_q <= cur_tag_d;
            cur_err_q <= cur_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cur_tag_d = cur_tag_q;
        cur_err_d = cur_err_q;
        pop       = 1'b0;
        load      = 1'b0;
        err_set   = 1'b0;
        case (state_q)
            // Busy must be low here too, so a run timeout waits out the decoder.
            IDLE: if (!fifo_empty && !bus.dec_busy) state_d = LAUNCH;
            LAUNCH: begin
                state_d = WAIT_ACK;
                cnt_d   = 12'd1;
            end
            WAIT_ACK: begin
                if (bus.dec_busy) begin
                    state_d   = RUN;
                    cnt_d     = 12'd1;
                    pop       = 1'b1;
                    cur_tag_d = head.tag;
                    cur_err_d = 1'b0;
                end else if (cnt_q == 12'(ACK_TIMEOUT)) begin
                    state_d   = CAPTURE;
                    pop       = 1'b1;
                    cur_tag_d = head.tag;
                    cur_err_d = 1'b1;
                    err_set   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 12'd1;
                end
            end
            RUN: begin
                if (!bus.dec_busy) begin
                    state_d = CAPTURE;
                end else if (cnt_q == 12'(RUN_TIMEOUT)) begin
                    state_d   = CAPTURE;
                    cur_err_d = 1'b1;
                    err_set   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 12'd1;
                end
            end
            CAPTURE: begin
                if (!m_valid_q || bus.m_ready) begin
                    load    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid_q   <= 1'b0;
            m_bits_q    <= 4'd0;
            m_tag_q     <= 4'd0;
            m_err_q     <= 1'b0;
            frames_done <= 16'd0;
            err_flag    <= 1'b0;
        end else begin
            if (load) begin
                m_valid_q   <= 1'b1;
                m_bits_q    <= cur_err_q ? 4'd0 : bus.dec_bits;
                m_tag_q     <= cur_tag_q;
                m_err_q     <= cur_err_q;
                frames_done <= frames_done + 16'd1;
            end else if (m_valid_q && bus.m_ready) begin
                m_valid_q <= 1'b0;
            end
            if (err_set)      err_flag <= 1'b1;
            else if (clr_err) err_flag <= 1'b0;
        end
    end
endmodule

// File: tb/tb_bp_frame_scheduler.sv
// Directed + randomized bench for bp_frame_scheduler with a behavioural
// decoder and a queue-based scoreboard of expected results.
module tb_bp_frame_scheduler;
    localparam int BIT = 8;

    typedef struct packed {
        logic [3:0] tag;
        logic [3:0] bits;
        logic       err;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr_err = 1'b0;
    logic [15:0] frames_done;
    logic        err_flag;

    bp_frame_scheduler_if #(.BIT(BIT)) bus ();

    bp_frame_scheduler #(.BIT(BIT), .ACK_TIMEOUT(4), .RUN_TIMEOUT(2047)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .clr_err(clr_err),
        .frames_done(frames_done), .err_flag(err_flag)
    );

    always #5 clk = ~clk;

    int   total = 0, bad = 0;
    res_t exp_q[$], got_q[$];
    int   gaps[$];
    int   n_start = 0, dbl_start = 0, since = 0;
    logic prev_start = 1'b0;
    logic [15:0] prev_fd = 16'd0;
    logic [3:0]  tag_ctr = 4'd0;

    // decoder behaviour: 0 = normal, 1 = never acks, 2 = stuck busy 3000 cycles
    int   dmode = 0, dlen = 10, dcnt = 0;
    logic [3:0] pend = 4'd0;
    logic hold_ready = 1'b0, rnd_ready = 1'b0;

    int n, st, fd0, ecyc, nst0;
    logic [63:0] llr;
    logic [3:0]  t0;

    // Hard decision of a BP output bit is the LLR sign.
    function automatic logic [3:0] sbits(input logic [63:0] l);
        return {l[63], l[55], l[47], l[31]};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.dec_busy <= 1'b0;
            bus.dec_bits <= 4'd0;
            dcnt         <= 0;
        end else if (dcnt != 0) begin
            dcnt <= dcnt - 1;
            if (dcnt == 1) begin
                bus.dec_busy <= 1'b0;
                bus.dec_bits <= pend;
            end
        end else if (bus.dec_start && dmode != 1) begin
            bus.dec_busy <= 1'b1;
            dcnt         <= (dmode == 2) ? 3000 : dlen;
            pend         <= sbits(bus.dec_llr);
        end
    end

    initial begin
        bus.m_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            bus.m_ready = hold_ready ? 1'b0 : (rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1);
        end
    end

    always @(negedge clk) begin
        if (frames_done != prev_fd) since = 0; else since++;
        prev_fd = frames_done;
        if (bus.dec_start) begin
            n_start++;
            gaps.push_back(since);
            if (prev_start) dbl_start++;
        end
        prev_start = bus.dec_start;
        if (rst_n && bus.m_valid && bus.m_ready)
            got_q.push_back(res_t'{tag: bus.m_tag, bits: bus.m_bits, err: bus.m_err});
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push(input logic [63:0] l, input logic e, output int stalls);
        bus.s_valid = 1'b1;
        bus.s_llr   = l;
        stalls      = 0;
        while (!bus.s_ready && stalls < 5000) begin @(posedge clk); #1; stalls++; end
        if (stalls >= 5000) check("push_timeout", 0, 1);
        @(posedge clk); #1;
        bus.s_valid = 1'b0;
        exp_q.push_back(res_t'{tag: tag_ctr, bits: e ? 4'd0 : sbits(l), err: e});
        tag_ctr++;
    endtask

    task automatic wait_start(output int cyc);
        cyc = 0;
        while (!bus.dec_start && cyc < 5000) begin @(posedge clk); #1; cyc++; end
        if (cyc >= 5000) check("start_timeout", 0, 1);
    endtask

    task automatic drain(input string ph);
        int   t;
        res_t e, g;
        t = 0;
        while (got_q.size() < exp_q.size() && t < 20000) begin @(posedge clk); #1; t++; end
        check({ph, "_count"}, got_q.size(), exp_q.size());
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            check({ph, "_tag"}, g.tag, e.tag);
            check({ph, "_bits"}, g.bits, e.bits);
            check({ph, "_err"}, g.err, e.err);
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic reset_checks(input string ph);
        check({ph, "_s_ready"}, bus.s_ready, 1);
        check({ph, "_dec_start"}, bus.dec_start, 0);
        check({ph, "_dec_llr"}, bus.dec_llr, 0);
        check({ph, "_m_valid"}, bus.m_valid, 0);
        check({ph, "_m_out"}, {bus.m_bits, bus.m_tag, bus.m_err}, 0);
        check({ph, "_frames_done"}, frames_done, 0);
        check({ph, "_err_flag"}, err_flag, 0);
    endtask

    initial begin
        bus.s_valid = 1'b0;
        bus.s_llr   = '0;
        repeat (3) @(posedge clk);
        #1;
        reset_checks("rst");
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // single frame, 1000-cycle decode, bits 1010
        dlen = 1000;
        llr  = 64'h807F_8011_2233_4455;
        push(llr, 1'b0, st);
        check("p1_head", bus.dec_llr, llr);
        wait_start(n);
        check("p1_start_lat", n, 1);
        n = 0;
        while (!bus.m_valid && n < 5000) begin @(posedge clk); #1; n++; end
        check("p1_mvalid_lat", n, 1003);
        check("p1_m_bits", bus.m_bits, 4'b1010);
        drain("p1");
        check("p1_fd", frames_done, 1);

        // three back-to-back frames
        dlen = $urandom_range(5, 20);
        push({$urandom, $urandom}, 1'b0, st);
        push({$urandom, $urandom}, 1'b0, st);
        check("p2_full", bus.s_ready, 0);
        push({$urandom, $urandom}, 1'b0, st);
        check("p2_stall", st, 2);
        drain("p2");
        check("p2_gap_a", gaps[gaps.size()-2], 1);
        check("p2_gap_b", gaps[gaps.size()-1], 1);

        // output back-pressure: stall in CAPTURE
        dlen = $urandom_range(5, 20);
        hold_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        fd0 = frames_done;
        push({$urandom, $urandom}, 1'b0, st);
        t0 = exp_q[0].tag;
        push({$urandom, $urandom}, 1'b0, st);
        n = 0;
        while (frames_done == 16'(fd0) && n < 1000) begin @(posedge clk); #1; n++; end
        repeat (2 * dlen + 40) @(posedge clk);
        #1;
        check("p3_fd_stalled", frames_done, 16'(fd0 + 1));
        check("p3_m_valid", bus.m_valid, 1);
        check("p3_m_tag", bus.m_tag, t0);
        hold_ready = 1'b0;
        drain("p3");

        // decoder never acknowledges
        check("p4_err_pre", err_flag, 0);
        dmode = 1;
        push({$urandom, $urandom}, 1'b1, st);
        wait_start(n);
        fd0 = frames_done;
        ecyc = -1;
        n = 0;
        while (frames_done == 16'(fd0) && n < 100) begin
            @(posedge clk); #1; n++;
            if (err_flag && ecyc < 0) ecyc = n;
        end
        check("p4_err_lat", ecyc, 5);
        check("p4_load_lat", n, 6);
        dmode = 0;
        dlen  = $urandom_range(3, 10);
        push({$urandom, $urandom}, 1'b0, st);
        drain("p4");
        check("p4_err_sticky", err_flag, 1);
        clr_err = 1'b1;
        @(posedge clk); #1;
        clr_err = 1'b0;
        check("p4_err_clr", err_flag, 0);

        // decoder stuck busy beyond the run watchdog
        dmode = 2;
        push({$urandom, $urandom}, 1'b1, st);
        wait_start(n);
        @(posedge clk); #1;
        dmode = 0;
        fd0 = frames_done;
        n = 0;
        while (frames_done == 16'(fd0) && n < 5000) begin @(posedge clk); #1; n++; end
        check("p5_run_to", n, 2049);
        check("p5_err_flag", err_flag, 1);
        nst0 = n_start;
        push({$urandom, $urandom}, 1'b0, st);
        n = 0;
        while (bus.dec_busy && n < 5000) begin @(posedge clk); #1; n++; end
        check("p5_no_start", n_start, nst0);
        drain("p5");

        // reset, then 17 random frames with random back-pressure
        rst_n = 1'b0;
        #1;
        reset_checks("rst2");
        @(posedge clk); #1;
        rst_n   = 1'b1;
        tag_ctr = 4'd0;
        rnd_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            dlen = $urandom_range(2, 12);
            push({$urandom, $urandom}, 1'b0, st);
        end
        drain("p6");
        rnd_ready = 1'b0;
        check("p6_fd", frames_done, 17);

        // reset while the decoder is running
        dlen = 200;
        push({$urandom, $urandom}, 1'b0, st);
        wait_start(n);
        repeat (20) @(posedge clk);
        #1;
        check("p7_in_run", bus.dec_busy, 1);
        rst_n = 1'b0;
        #1;
        reset_checks("rst3");
        exp_q.delete();
        tag_ctr = 4'd0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        dlen = 8;
        push({$urandom, $urandom}, 1'b0, st);
        drain("p7");
        check("p7_fd", frames_done, 1);

        check("start_width", dbl_start, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
